// File: rtl/timer_pkg.sv
// Shared constants and types for the playback timer and its display paths.
package timer_pkg;

  localparam int unsigned SECONDS_PER_MINUTE = 60;
  localparam int unsigned SECONDS_PER_TEN    = 10;
  localparam int unsigned WRAP_SECONDS       = 600;
  localparam int unsigned DIGIT_W            = 6;
  localparam int unsigned ADDER_W            = 6;
  localparam int unsigned TOTAL_W            = 10;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [TOTAL_W-1:0] total_t;

endpackage : timer_pkg

// File: rtl/seconds_to_digits.sv
// Combinational split of an elapsed-seconds value (0..599) into M:SS digits.
module seconds_to_digits
  import timer_pkg::*;
#(
  parameter int unsigned DIGIT_W = timer_pkg::DIGIT_W
) (
  input  total_t             total_i,
  output logic [DIGIT_W-1:0] minutes0_o,
  output logic [DIGIT_W-1:0] seconds1_o,
  output logic [DIGIT_W-1:0] seconds0_o
);

  localparam total_t MINUTE_C = total_t'(SECONDS_PER_MINUTE);
  localparam total_t TEN_C    = total_t'(SECONDS_PER_TEN);

  total_t sec_in_min;

  // Constant divide/modulo decode; upper digit bits fall out as zero.
  always_comb begin
    sec_in_min = total_i % MINUTE_C;
    minutes0_o = DIGIT_W'(total_i / MINUTE_C);
    seconds1_o = DIGIT_W'(sec_in_min / TEN_C);
    seconds0_o = DIGIT_W'(sec_in_min % TEN_C);
  end

endmodule : seconds_to_digits

// File: rtl/playback_timer.sv
// Elapsed play-time accumulator with modulo-600 wrap and M:SS digit outputs.
module playback_timer
  import timer_pkg::*;
#(
  parameter int unsigned ADDER_W      = timer_pkg::ADDER_W,
  parameter int unsigned DIGIT_W      = timer_pkg::DIGIT_W,
  parameter int unsigned WRAP_SECONDS = timer_pkg::WRAP_SECONDS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               count,
  input  logic [ADDER_W-1:0] adder,
  output logic [DIGIT_W-1:0] seconds0,
  output logic [DIGIT_W-1:0] seconds1,
  output logic [DIGIT_W-1:0] minutes0
);

  localparam int unsigned SUM_W  = TOTAL_W + 1;
  localparam logic [SUM_W-1:0] WRAP_C = SUM_W'(WRAP_SECONDS);

  total_t           total_q;
  total_t           total_d;
  logic [SUM_W-1:0] sum_c;

  // Next elapsed time: add on enable, one subtraction suffices since adder < wrap.
  always_comb begin
    total_d = total_q;
    sum_c   = SUM_W'(total_q) + SUM_W'(adder);
    if (count) begin
      if (sum_c >= WRAP_C) begin
        total_d = TOTAL_W'(sum_c - WRAP_C);
      end else begin
        total_d = TOTAL_W'(sum_c);
      end
    end
  end

  // Elapsed-time register; reset clears it immediately, independent of clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  seconds_to_digits #(
    .DIGIT_W (DIGIT_W)
  ) u_digits (
    .total_i    (total_q),
    .minutes0_o (minutes0),
    .seconds1_o (seconds1),
    .seconds0_o (seconds0)
  );

endmodule : playback_timer

// File: tb/tb_playback_timer.sv
// Bench for playback_timer: reference model feeds an expected-time queue.
module tb_playback_timer;

  logic       clk;
  logic       reset;
  logic       count;
  logic [5:0] adder;
  logic [5:0] seconds0;
  logic [5:0] seconds1;
  logic [5:0] minutes0;

  int n_checks;
  int n_fails;
  int exp_total;
  int exp_q[$];

  playback_timer dut (
    .clk      (clk),
    .reset    (reset),
    .count    (count),
    .adder    (adder),
    .seconds0 (seconds0),
    .seconds1 (seconds1),
    .minutes0 (minutes0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_time(input string tag, input int m, input int s1, input int s0);
    check_val({tag, ".m0"}, 32'(minutes0), m);
    check_val({tag, ".s1"}, 32'(seconds1), s1);
    check_val({tag, ".s0"}, 32'(seconds0), s0);
  endtask

  // Drive one cycle, advance the model at the edge, compare just after it.
  task automatic tick(input logic c, input logic [5:0] a);
    int t;
    count = c;
    adder = a;
    @(posedge clk);
    if (c) begin
      exp_total = exp_total + int'(a);
      if (exp_total >= 600) exp_total = exp_total - 600;
    end
    exp_q.push_back(exp_total);
    #1;
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 0, 1);
    end else begin
      t = exp_q.pop_front();
      check_time("model", t / 60, (t % 60) / 10, t % 10);
    end
  endtask

  task automatic run(input int n, input logic c, input logic [5:0] a);
    for (int i = 0; i < n; i++) tick(c, a);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    exp_total = 0;
    check_time(tag, 0, 0, 0);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    exp_total = 0;
    reset     = 1'b0;
    count     = 1'b1;
    adder     = 6'd1;
    #17;
    check_time("reset", 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    run(100, 1'b1, 6'd1);
    check_time("t_1_40", 1, 4, 0);
    run(100, 1'b0, 6'd1);
    check_time("hold_1_40", 1, 4, 0);
    run(5, 1'b1, 6'd1);
    check_time("t_1_45", 1, 4, 5);

    async_reset("midrun_reset");
    tick(1'b1, 6'd1);
    check_time("resume_0_01", 0, 0, 1);
    tick(1'b1, 6'd1);
    check_time("resume_0_02", 0, 0, 2);

    async_reset("rst_adder");
    run(8, 1'b1, 6'd8);
    check_time("t_1_04", 1, 0, 4);
    run(4, 1'b1, 6'd15);
    check_time("t_2_04", 2, 0, 4);
    run(10, 1'b1, 6'd0);
    check_time("adder0_2_04", 2, 0, 4);

    async_reset("rst_wrap1");
    run(9, 1'b1, 6'd63);
    tick(1'b1, 6'd32);
    check_time("t_9_59", 9, 5, 9);
    tick(1'b1, 6'd1);
    check_time("wrap_0_00", 0, 0, 0);

    async_reset("rst_wrap15");
    run(9, 1'b1, 6'd63);
    tick(1'b1, 6'd23);
    check_time("t_9_50", 9, 5, 0);
    tick(1'b1, 6'd15);
    check_time("wrap_0_05", 0, 0, 5);

    async_reset("rst_wrap63");
    run(9, 1'b1, 6'd63);
    tick(1'b1, 6'd31);
    check_time("t_9_58", 9, 5, 8);
    tick(1'b1, 6'd63);
    check_time("wrap_1_01", 1, 0, 1);

    for (int i = 0; i < 10000; i++) begin
      tick(1'($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63)));
      check_val("total_range", int'(dut.total_q < 10'd600), 1);
      check_val("s1_le_5", int'(seconds1 <= 6'd5), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule : tb_playback_timer

// File: doc/playback_timer.md
Name: playback_timer

Overview:
- Elapsed-time counter for the music player. Displays play time as M:SS on three digit outputs.
- Each enabled clock cycle represents one time tick. On each tick the elapsed time advances by a programmable number of seconds (`adder`), which supports fast-forward.
- Sits between the player control FSM (drives `count`/`reset`) and the display decoders (consume the digits).

Parameters:
- ADDER_W, 6, width of the `adder` input in bits.
- DIGIT_W, 6, width of each digit output (values are zero-extended).
- WRAP_SECONDS, 600, total-seconds modulus (wraps after 9:59).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; clears elapsed time to 0:00.
- count  input  1  enable; 1 = advance on each clk edge, 0 = hold.
- adder  input  ADDER_W  seconds added per enabled cycle, 0..63.
- seconds0  output  DIGIT_W  seconds units digit, 0..9.
- seconds1  output  DIGIT_W  seconds tens digit, 0..5.
- minutes0  output  DIGIT_W  minutes digit, 0..9.

Behaviour:
- State: one register `total`, 10 bits unsigned, holding elapsed seconds in the range 0..599.
- Reset:
  - `reset`=0 clears `total` to 0 immediately, without waiting for clk.
  - All three outputs read 0 while `reset` is low.
  - Reset has priority over `count`.
  - Deasserting reset mid-run restarts counting from 0 at the next enabled edge.
- Update on rising clk when `reset`=1:
  - `count`=1: sum = `total` + `adder`, computed at 11 bits. If sum >= 600, `total` <= sum - 600; else `total` <= sum.
  - A single subtraction is sufficient because `adder` <= 63 < 600.
  - `count`=0: `total` holds.
  - `adder`=0 with `count`=1: `total` holds.
- `adder` and `count` are sampled at the clock edge. Changing `adder` mid-run takes effect on the next edge; no pipeline.
- Outputs are a combinational decode of `total`, so they change in the same cycle the register updates (latency 1 clk from the sampled inputs):
  - minutes0 = `total` / 60
  - seconds1 = (`total` % 60) / 10
  - seconds0 = `total` % 10
  - Upper unused bits are 0.
- Outputs are always valid BCD-style digits: seconds1 never exceeds 5, minutes0 never exceeds 9.
- Wrap: 9:59 + 1 -> 0:00. Carry across digit boundaries is exact for any `adder` value, e.g. 0:58 + 15 -> 1:13.
- No overflow flag and no saturation.
- `total` must never hold a value >= 600. Verification asserts this on every cycle.

Decomposition:
- Shared package `timer_pkg`:
  - constants SECONDS_PER_MINUTE=60, SECONDS_PER_TEN=10, WRAP_SECONDS=600, DIGIT_W=6, ADDER_W=6.
  - typedef `digit_t` (logic [DIGIT_W-1:0]).
  - typedef `total_t` (logic [9:0]).
- One sub-module `seconds_to_digits`: purely combinational conversion of `total` (0..599) into minutes0/seconds1/seconds0.
  - Implement by constant divide/modulo or a shift-add/double-dabble style conversion.
  - Shared with other display paths.
- Top level contains only the accumulator, the wrap logic and the reset handling.

Test Plan:
- Reset low, then release with `count`=1, `adder`=1. After 100 rising edges -> 1:40 (minutes0=1, seconds1=4, seconds0=0).
- From 1:40, set `count`=0 for 100 cycles -> outputs stay 1:40. Set `count`=1 for 5 cycles -> 1:45.
- Pull `reset` low between clock edges mid-run -> outputs read 0:00 immediately, before the next edge. Release reset -> counting resumes 0:01, 0:02, ...
- From 0:00, `adder`=8 for 8 cycles -> 1:04. Then `adder`=15 for 4 cycles -> 2:04. Then `adder`=0 for 10 cycles -> holds at 2:04.
- Wrap: `adder`=1 from 9:59 (599) -> 0:00. `adder`=15 from 9:50 (590) -> 0:05. `adder`=63 from 9:58 (598) -> 1:01.
- Random `adder`/`count` for 10k cycles against a reference model: `total` stays < 600 and seconds1 <= 5 on every cycle.
